// File: rtl/proc_rf_sb.sv
// Integer register file with two read ports, one write port, a per-register
// busy scoreboard, optional write-to-read forwarding and a post-reset clear sweep.
module proc_rf_sb #(
  parameter int  XLEN   = 64,
  parameter int  NREG   = 32,
  parameter bit  BYPASS = 1'b1,
  localparam int AW     = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            init_done,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  output logic            busy1,
  output logic            busy2,
  input  logic            issue_en,
  input  logic [AW-1:0]   issue_rd,
  input  logic            reg_write,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] wdata,
  input  logic            flush
);

  // state   | meaning
  // S_CLEAR | sweeping zeros into mem, one register per cycle; traffic ignored
  // S_RUN   | normal operation; reads, writes and scoreboard active
  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;

  logic [0:0]      state;
  logic [AW-1:0]   ptr;
  logic [XLEN-1:0] mem [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic            run;
  logic            wr_run;
  logic            mem_we;
  logic [AW-1:0]   mem_wa;
  logic [XLEN-1:0] mem_wd;
  logic            fwd1;
  logic            fwd2;

  assign run       = (state == S_RUN);
  assign init_done = run;
  assign wr_run    = run && reg_write && (rd != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_CLEAR;
      ptr   <= '0;
    end else begin
      case (state)
        S_CLEAR: begin
          ptr <= ptr + 1'b1;
          if (ptr == AW'(NREG - 1)) state <= S_RUN;
        end
        default: ;
      endcase
    end
  end

  // The sweep and writeback share one write port so mem stays RAM-like.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = ptr;
    mem_wd = '0;
    if (!rst) begin
      if (!run) begin
        mem_we = 1'b1;
      end else if (wr_run) begin
        mem_we = 1'b1;
        mem_wa = rd;
        mem_wd = wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  // Flush overrides everything; an issue to the register being written back wins.
  always_comb begin
    busy_nxt = busy;
    if (run) begin
      if (flush) begin
        busy_nxt = '0;
      end else begin
        if (wr_run) busy_nxt[rd] = 1'b0;
        if (issue_en && (issue_rd != '0)) busy_nxt[issue_rd] = 1'b1;
      end
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  assign fwd1 = BYPASS && reg_write && (rd == rs1) && (rs1 != '0);
  assign fwd2 = BYPASS && reg_write && (rd == rs2) && (rs2 != '0);

  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (run && (rs1 != '0)) rdata1 = fwd1 ? wdata : mem[rs1];
    if (run && (rs2 != '0)) rdata2 = fwd2 ? wdata : mem[rs2];
  end

  assign busy1 = run && busy[rs1] && !fwd1;
  assign busy2 = run && busy[rs2] && !fwd2;

endmodule

// File: tb/tb_proc_rf_sb.sv
// Scoreboard bench: a forwarding and a non-forwarding instance share stimulus
// and are checked every cycle against a register/busy-array reference model.
module tb_proc_rf_sb;
  localparam int XLEN = 64;
  localparam int NREG = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [4:0]      rs1 = '0, rs2 = '0, issue_rd = '0, rd = '0;
  logic            issue_en = 1'b0, reg_write = 1'b0, flush = 1'b0;
  logic [XLEN-1:0] wdata = '0;

  logic            idn_b, b1_b, b2_b, idn_n, b1_n, b2_n;
  logic [XLEN-1:0] r1_b, r2_b, r1_n, r2_n;

  always #5 clk = ~clk;

  proc_rf_sb #(.XLEN(XLEN), .NREG(NREG), .BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .init_done(idn_b), .rs1(rs1), .rs2(rs2),
    .rdata1(r1_b), .rdata2(r2_b), .busy1(b1_b), .busy2(b2_b),
    .issue_en(issue_en), .issue_rd(issue_rd), .reg_write(reg_write),
    .rd(rd), .wdata(wdata), .flush(flush));

  proc_rf_sb #(.XLEN(XLEN), .NREG(NREG), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .init_done(idn_n), .rs1(rs1), .rs2(rs2),
    .rdata1(r1_n), .rdata2(r2_n), .busy1(b1_n), .busy2(b2_n),
    .issue_en(issue_en), .issue_rd(issue_rd), .reg_write(reg_write),
    .rd(rd), .wdata(wdata), .flush(flush));

  typedef struct {
    int              cyc;
    bit              idn;
    logic [XLEN-1:0] r1_b, r2_b, r1_n, r2_n;
    bit              b1_b, b2_b, b1_n, b2_n;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_no = 0;

  // Reference model: architectural register values, busy flags, sweep progress.
  logic [XLEN-1:0] m_mem [NREG];
  bit              m_busy [NREG];
  bit              m_init = 1'b0;
  bit              m_valid = 1'b0;
  int              m_cnt = 0;

  function automatic void predict(input bit byp, input logic [4:0] a, input bit we,
                                  input logic [4:0] w_rd, input logic [XLEN-1:0] wd,
                                  output logic [XLEN-1:0] d, output bit b);
    d = '0;
    b = 1'b0;
    if (m_init && a != 0) begin
      if (byp && we && w_rd == a) d = wd;
      else begin
        d = m_mem[a];
        b = m_busy[a];
      end
    end
  endfunction

  function automatic void model_edge(input bit r, input bit we, input logic [4:0] w_rd,
                                     input logic [XLEN-1:0] wd, input bit iss,
                                     input logic [4:0] ird, input bit fl);
    if (r) begin
      m_init = 1'b0;
      m_cnt  = 0;
      for (int i = 0; i < NREG; i++) begin
        m_mem[i]  = '0;
        m_busy[i] = 1'b0;
      end
      m_valid = 1'b1;
    end else if (!m_init) begin
      m_cnt++;
      if (m_cnt == NREG) m_init = 1'b1;
    end else begin
      if (we && w_rd != 0) m_mem[w_rd] = wd;
      if (fl) begin
        for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
      end else begin
        if (we && w_rd != 0) m_busy[w_rd] = 1'b0;
        if (iss && ird != 0) m_busy[ird] = 1'b1;
      end
    end
  endfunction

  task automatic cyc(input bit r, input bit we, input logic [4:0] w_rd,
                     input logic [XLEN-1:0] wd, input bit iss, input logic [4:0] ird,
                     input bit fl, input logic [4:0] a1, input logic [4:0] a2);
    exp_t e;
    rst = r; reg_write = we; rd = w_rd; wdata = wd;
    issue_en = iss; issue_rd = ird; flush = fl; rs1 = a1; rs2 = a2;
    if (m_valid) begin
      e.cyc = cyc_no;
      e.idn = m_init;
      predict(1'b1, a1, we, w_rd, wd, e.r1_b, e.b1_b);
      predict(1'b1, a2, we, w_rd, wd, e.r2_b, e.b2_b);
      predict(1'b0, a1, we, w_rd, wd, e.r1_n, e.b1_n);
      predict(1'b0, a2, we, w_rd, wd, e.r2_n, e.b2_n);
      exp_q.push_back(e);
    end
    @(posedge clk);
    model_edge(r, we, w_rd, wd, iss, ird, fl);
    cyc_no++;
    #1;
  endtask

  task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
    cyc(1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, 1'b0, a1, a2);
  endtask

  function automatic void chk(input string nm, input int c,
                              input logic [XLEN-1:0] act, input logic [XLEN-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, c, act, expv);
    end
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("init_done_byp", e.cyc, 64'(idn_b), 64'(e.idn));
        chk("init_done_nob", e.cyc, 64'(idn_n), 64'(e.idn));
        chk("rdata1_byp", e.cyc, r1_b, e.r1_b);
        chk("rdata2_byp", e.cyc, r2_b, e.r2_b);
        chk("rdata1_nob", e.cyc, r1_n, e.r1_n);
        chk("rdata2_nob", e.cyc, r2_n, e.r2_n);
        chk("busy1_byp", e.cyc, 64'(b1_b), 64'(e.b1_b));
        chk("busy2_byp", e.cyc, 64'(b2_b), 64'(e.b2_b));
        chk("busy1_nob", e.cyc, 64'(b1_n), 64'(e.b1_n));
        chk("busy2_nob", e.cyc, 64'(b2_n), 64'(e.b2_n));
      end
    end
  end

  initial begin : driver
    logic [4:0]      w, a, b, ir;
    logic [XLEN-1:0] d;
    int              guard;

    // Reset held two cycles, then the sweep with writes to x4 that must be dropped.
    cyc(1'b1, 1'b0, 5'd0, '0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    cyc(1'b1, 1'b0, 5'd0, '0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    for (int i = 0; i < NREG; i++)
      cyc(1'b0, 1'b1, 5'd4, 64'hABCD, 1'b1, 5'd4, 1'b0, 5'(i), 5'd4);
    for (int i = 0; i < NREG; i++) idle(5'(i), 5'd4);

    // Plain write/read and the hard-wired zero register.
    cyc(1'b0, 1'b1, 5'd5, 64'hDEAD_BEEF_0123_4567, 1'b0, 5'd0, 1'b0, 5'd1, 5'd0);
    idle(5'd5, 5'd0);
    cyc(1'b0, 1'b1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    idle(5'd5, 5'd0);

    // Same-cycle forwarding versus no forwarding.
    cyc(1'b0, 1'b1, 5'd7, 64'h22, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    cyc(1'b0, 1'b1, 5'd7, 64'h11, 1'b0, 5'd0, 1'b0, 5'd7, 5'd7);
    idle(5'd7, 5'd7);

    // Scoreboard set, clear through writeback, set-wins collision, x0 issue.
    cyc(1'b0, 1'b0, 5'd0, '0, 1'b1, 5'd3, 1'b0, 5'd3, 5'd3);
    idle(5'd3, 5'd3);
    cyc(1'b0, 1'b1, 5'd3, 64'h9, 1'b0, 5'd0, 1'b0, 5'd3, 5'd2);
    idle(5'd3, 5'd3);
    cyc(1'b0, 1'b1, 5'd3, 64'hA, 1'b1, 5'd3, 1'b0, 5'd3, 5'd0);
    idle(5'd3, 5'd3);
    cyc(1'b0, 1'b0, 5'd0, '0, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0);
    idle(5'd0, 5'd3);

    // Flush beats a simultaneous issue; the simultaneous write still lands.
    cyc(1'b0, 1'b0, 5'd0, '0, 1'b1, 5'd1, 1'b0, 5'd1, 5'd2);
    cyc(1'b0, 1'b0, 5'd0, '0, 1'b1, 5'd2, 1'b0, 5'd1, 5'd2);
    cyc(1'b0, 1'b0, 5'd0, '0, 1'b1, 5'd3, 1'b0, 5'd2, 5'd3);
    cyc(1'b0, 1'b1, 5'd2, 64'h5, 1'b1, 5'd4, 1'b1, 5'd1, 5'd3);
    idle(5'd1, 5'd2);
    idle(5'd3, 5'd4);

    // Fill every register, reset for one cycle, and confirm a fresh clear sweep.
    for (int i = 1; i < NREG; i++)
      cyc(1'b0, 1'b1, 5'(i), 64'(i), 1'b1, 5'(i), 1'b0, 5'(i), 5'(i - 1));
    for (int i = 1; i < NREG; i++) cyc(1'b0, 1'b0, 5'd0, '0, 1'b1, 5'(i), 1'b0, 5'(i), 5'd1);
    cyc(1'b1, 1'b0, 5'd0, '0, 1'b0, 5'd0, 1'b0, 5'd9, 5'd10);
    for (int i = 0; i < NREG; i++) idle(5'(i), 5'(NREG - 1 - i));
    for (int i = 0; i < NREG; i++) idle(5'(i), 5'(NREG - 1 - i));

    // Random traffic, with reads biased toward the current write target.
    for (int n = 0; n < 800; n++) begin
      w  = 5'($urandom_range(0, NREG - 1));
      ir = 5'($urandom_range(0, NREG - 1));
      a  = ($urandom_range(0, 2) == 0) ? w : 5'($urandom_range(0, NREG - 1));
      b  = ($urandom_range(0, 3) == 0) ? ir : 5'($urandom_range(0, NREG - 1));
      d  = {$urandom, $urandom};
      cyc($urandom_range(0, 399) == 0, $urandom_range(0, 1) == 1, w, d,
          $urandom_range(0, 2) == 0, ir, $urandom_range(0, 24) == 0, a, b);
    end
    idle(5'd0, 5'd0);

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    #1;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected responses left unchecked, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
